// File: rtl/condicionador_botoes.sv
// Push-button front end: 2-FF synchronisers, per-channel debounce, and a Moore FSM
// that turns a clean single-button press into a one-cycle jogada pulse with a latched code.
module condicionador_botoes #(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CICLOS = 1000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                iniciar_in,
   input  logic [N_BOTOES-1:0] botoes_in,
   output logic [N_BOTOES-1:0] botoes_out,
   output logic                jogada_pulso,
   output logic [N_BOTOES-1:0] jogada_codigo,
   output logic                iniciar_pulso,
   output logic                multiplo,
   output logic [3:0]          db_estado
);

   localparam int N_CANAIS = N_BOTOES + 1;
   localparam int CW       = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      PULSO  = 2'd1,
      ESPERA = 2'd2,
      ERRO   = 2'd3
   } estado_t;

   logic [N_CANAIS-1:0] raw, s1, s2, stable;
   logic [CW-1:0]       cnt [N_CANAIS];
   logic                stable_ini_q;
   logic                captura;
   estado_t             estado, prox_estado;

   // Channel N_BOTOES carries iniciar; the low bits are the game buttons.
   assign raw = {iniciar_in, botoes_in};

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its source, which is what makes s1 -> s2 a real 2-stage chain.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stable <= '0;
         for (int i = 0; i < N_CANAIS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CANAIS; i++) begin
            if (s2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_FIM) begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign botoes_out = stable[N_BOTOES-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         stable_ini_q  <= 1'b0;
         iniciar_pulso <= 1'b0;
      end else begin
         stable_ini_q  <= stable[N_BOTOES];
         iniciar_pulso <= stable[N_BOTOES] & ~stable_ini_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado        <= OCIOSO;
         jogada_codigo <= '0;
      end else begin
         estado <= prox_estado;
         if (captura) jogada_codigo <= botoes_out;
      end
   end

   // NOTE: defaults first, so no path through this block can leave a signal
   // unassigned and infer a latch.
   always_comb begin
      prox_estado = estado;
      captura     = 1'b0;
      case (estado)
         OCIOSO: begin
            if ($onehot(botoes_out)) begin
               prox_estado = PULSO;
               captura     = 1'b1;
            end else if (botoes_out != '0) begin
               prox_estado = ERRO;
            end
         end
         PULSO:        prox_estado = ESPERA;
         ESPERA, ERRO: if (botoes_out == '0) prox_estado = OCIOSO;
         default:      prox_estado = OCIOSO;
      endcase
   end

   assign jogada_pulso = (estado == PULSO);
   assign multiplo     = (estado == ERRO);
   assign db_estado    = {2'b00, estado};

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes with DEBOUNCE_CICLOS=4: directed scenarios plus random
// stimulus, compared each cycle with a window-based behavioural model of the conditioner.
module tb_condicionador_botoes;

   localparam int N = 4;
   localparam int D = 4;

   logic         clock = 1'b0;
   logic         reset;
   logic         iniciar_in;
   logic [N-1:0] botoes_in;
   logic [N-1:0] botoes_out;
   logic         jogada_pulso;
   logic [N-1:0] jogada_codigo;
   logic         iniciar_pulso;
   logic         multiplo;
   logic [3:0]   db_estado;

   int n_vec = 0;
   int n_err = 0;

   condicionador_botoes #(.N_BOTOES(N), .DEBOUNCE_CICLOS(D)) dut (
      .clock         (clock),
      .reset         (reset),
      .iniciar_in    (iniciar_in),
      .botoes_in     (botoes_in),
      .botoes_out    (botoes_out),
      .jogada_pulso  (jogada_pulso),
      .jogada_codigo (jogada_codigo),
      .iniciar_pulso (iniciar_pulso),
      .multiplo      (multiplo),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   // Model: hist[j] is the raw input sampled j+1 edges ago; a level is accepted once
   // the D synchronised samples preceding the edge all agree and differ from it.
   logic [N:0]   hist [0:D];
   logic [N-1:0] m_stable, m_codigo;
   logic         m_ini, m_ini_q, m_ini_pulso;
   bit           m_busy, m_erro, m_pulse;

   function automatic logic [14:0] obs();
      return {botoes_out, jogada_pulso, jogada_codigo, iniciar_pulso, multiplo, db_estado};
   endfunction

   function automatic logic [14:0] expv();
      logic [3:0] db;
      db = m_pulse ? 4'd1 : m_erro ? 4'd3 : m_busy ? 4'd2 : 4'd0;
      return {m_stable, m_pulse, m_codigo, m_ini_pulso, m_erro, db};
   endfunction

   task automatic tick();
      logic [N:0] r;
      logic [N:0] cur;
      bit         rst;
      logic       v;
      bit         all_eq;
      r   = {iniciar_in, botoes_in};
      rst = reset;
      @(posedge clock);
      if (rst) begin
         for (int j = 0; j <= D; j++) hist[j] = '0;
         m_stable = '0; m_codigo = '0;
         m_ini = 0; m_ini_q = 0; m_ini_pulso = 0;
         m_busy = 0; m_erro = 0; m_pulse = 0;
      end else begin
         if (m_pulse) begin
            m_pulse = 0;
         end else if (!m_busy) begin
            if ($countones(m_stable) == 1) begin
               m_pulse = 1; m_busy = 1; m_codigo = m_stable;
            end else if (m_stable != '0) begin
               m_busy = 1; m_erro = 1;
            end
         end else if (m_stable == '0) begin
            m_busy = 0; m_erro = 0;
         end
         m_ini_pulso = m_ini & ~m_ini_q;
         m_ini_q     = m_ini;
         cur = {m_ini, m_stable};
         for (int c = 0; c <= N; c++) begin
            v      = hist[1][c];
            all_eq = 1;
            for (int j = 2; j <= D; j++) if (hist[j][c] != v) all_eq = 0;
            if (all_eq && v != cur[c]) cur[c] = v;
         end
         m_ini    = cur[N];
         m_stable = cur[N-1:0];
         for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
         hist[0] = r;
      end
      #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1; iniciar_in = 1'b0; botoes_in = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      n_vec++;
      if (obs() !== 15'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b, want %b", obs(), 15'd0);
      end
   endtask

   task automatic test_single_press();
      int pulses = 0;
      botoes_in = 4'b0100;
      for (int e = 0; e <= 9; e++) begin
         tick();
         pulses += int'(jogada_pulso);
         n_vec++;
         if (obs() !== expv()) begin
            n_err++;
            $display("FAIL single_model e=%0d: got %b, want %b", e, obs(), expv());
         end
         if (e == 4 || e == 5) begin
            n_vec++;
            if (botoes_out !== (e == 5 ? 4'b0100 : 4'b0000)) begin
               n_err++;
               $display("FAIL single_latency e=%0d: botoes_out %b", e, botoes_out);
            end
         end
         if (e == 6) begin
            n_vec++;
            if (jogada_pulso !== 1'b1) begin
               n_err++;
               $display("FAIL single_pulse_edge6: got %b, want 1", jogada_pulso);
            end
         end
      end
      n_vec++;
      if (pulses != 1 || jogada_codigo !== 4'b0100) begin
         n_err++;
         $display("FAIL single_count: pulses %0d code %b, want 1 and 0100", pulses, jogada_codigo);
      end
      botoes_in = '0;
      repeat (10) tick();
   endtask

   task automatic test_glitch();
      bit bad = 0;
      botoes_in = 4'b0010;
      repeat (3) begin
         tick();
         if (botoes_out !== 4'b0 || jogada_pulso !== 1'b0 || db_estado !== 4'd0) bad = 1;
      end
      botoes_in = '0;
      repeat (10) begin
         tick();
         if (botoes_out !== 4'b0 || jogada_pulso !== 1'b0 || db_estado !== 4'd0) bad = 1;
         n_vec++;
         if (obs() !== expv()) begin
            n_err++;
            $display("FAIL glitch_model: got %b, want %b", obs(), expv());
         end
      end
      n_vec++;
      if (bad) begin
         n_err++;
         $display("FAIL glitch_filtered: glitch reached outputs, want none");
      end
   endtask

   task automatic test_espera_extra();
      int pulses = 0;
      botoes_in = 4'b0001;
      repeat (9) begin tick(); pulses += int'(jogada_pulso); end
      botoes_in = 4'b0011;
      repeat (12) begin
         tick();
         pulses += int'(jogada_pulso);
         n_vec++;
         if (obs() !== expv()) begin
            n_err++;
            $display("FAIL espera_model: got %b, want %b", obs(), expv());
         end
      end
      n_vec++;
      if (pulses != 1 || jogada_codigo !== 4'b0001 || db_estado !== 4'd2) begin
         n_err++;
         $display("FAIL espera_extra: pulses %0d code %b db %0d, want 1 0001 2",
                  pulses, jogada_codigo, db_estado);
      end
      botoes_in = '0;
      repeat (10) tick();
      n_vec++;
      if (db_estado !== 4'd0) begin
         n_err++;
         $display("FAIL espera_release: db %0d, want 0", db_estado);
      end
   endtask

   task automatic test_multiplo();
      int pulses = 0;
      botoes_in = 4'b0011;
      repeat (9) begin tick(); pulses += int'(jogada_pulso); end
      n_vec++;
      if (db_estado !== 4'd3 || multiplo !== 1'b1 || pulses != 0 || jogada_codigo !== 4'b0001) begin
         n_err++;
         $display("FAIL multiplo_erro: db %0d mult %b pulses %0d code %b, want 3 1 0 0001",
                  db_estado, multiplo, pulses, jogada_codigo);
      end
      botoes_in = '0;
      repeat (10) tick();
      n_vec++;
      if (multiplo !== 1'b0 || db_estado !== 4'd0 || obs() !== expv()) begin
         n_err++;
         $display("FAIL multiplo_release: got %b, want %b", obs(), expv());
      end
   endtask

   task automatic test_iniciar();
      int pulses = 0;
      iniciar_in = 1'b1;
      for (int e = 0; e < 20; e++) begin
         tick();
         pulses += int'(iniciar_pulso);
         if (e == 5 || e == 6) begin
            n_vec++;
            if (iniciar_pulso !== (e == 6)) begin
               n_err++;
               $display("FAIL iniciar_edge e=%0d: got %b, want %b", e, iniciar_pulso, e == 6);
            end
         end
      end
      iniciar_in = 1'b0;
      repeat (20) begin tick(); pulses += int'(iniciar_pulso); end
      n_vec++;
      if (pulses != 1) begin
         n_err++;
         $display("FAIL iniciar_count: got %0d pulses, want 1", pulses);
      end
   endtask

   task automatic test_reset_mid_press();
      botoes_in = 4'b0010;
      repeat (9) tick();
      n_vec++;
      if (db_estado !== 4'd2) begin
         n_err++;
         $display("FAIL midreset_espera: db %0d, want 2", db_estado);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++;
      if (obs() !== 15'd0) begin
         n_err++;
         $display("FAIL midreset_clear: got %b, want 0", obs());
      end
      for (int e = 1; e <= 9; e++) begin
         tick();
         if (e == 6 || e == 7) begin
            n_vec++;
            if (jogada_pulso !== (e == 7)) begin
               n_err++;
               $display("FAIL midreset_repulse e=%0d: got %b, want %b", e, jogada_pulso, e == 7);
            end
         end
      end
      n_vec++;
      if (jogada_codigo !== 4'b0010 || obs() !== expv()) begin
         n_err++;
         $display("FAIL midreset_model: got %b, want %b", obs(), expv());
      end
      botoes_in = '0;
      repeat (10) tick();
   endtask

   task automatic test_random();
      int sel;
      for (int seg = 0; seg < 150; seg++) begin
         sel = $urandom_range(0, 9);
         if (sel < 3)      botoes_in = '0;
         else if (sel < 7) botoes_in = 4'b0001 << $urandom_range(0, 3);
         else              botoes_in = 4'($urandom);
         if ($urandom_range(0, 2) == 0) iniciar_in = 1'($urandom);
         reset = ($urandom_range(0, 59) == 0);
         repeat ($urandom_range(1, 9)) begin
            tick();
            reset = 1'b0;
            n_vec++;
            if (obs() !== expv()) begin
               n_err++;
               $display("FAIL random_seg%0d: got %b, want %b", seg, obs(), expv());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_espera_extra();
      test_multiplo();
      test_iniciar();
      test_reset_mid_press();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
